// File: rtl/ex_mem_reg.sv
// ============================================================================
//  Module      : ex_mem_reg
//  Description : EX/MEM pipeline register with stall (hold), flush (bubble)
//                and load/store alignment checking. A misaligned access is
//                turned into a bubble and raises a sticky trap that holds
//                the pipeline in bubbles until the handler acknowledges it.
//                Optional performance counters are enabled by defining the
//                macro EX_MEM_REG_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [REG_W-1:0]  write_register_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [5:0]        opcode_in,
  input  logic              trap_ack_in,
`ifdef EX_MEM_REG_PERF_EN
  input  logic              perf_clear_in,
  output logic [31:0]       perf_loads_out,
  output logic [31:0]       perf_stores_out,
  output logic [31:0]       perf_traps_out,
`endif
  output logic              valid_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  write_register_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out,
  output logic [5:0]        opcode_out,
  output logic              trap_out,
  output logic [DATA_W-1:0] badvaddr_out,
  output logic [1:0]        trap_cause_out
);

  // Memory opcodes, matching the mips_pkg OPCODE_* encodings.
  localparam logic [5:0] c_OPCODE_LB  = 6'h20;
  localparam logic [5:0] c_OPCODE_LH  = 6'h21;
  localparam logic [5:0] c_OPCODE_LW  = 6'h23;
  localparam logic [5:0] c_OPCODE_LBU = 6'h24;
  localparam logic [5:0] c_OPCODE_LHU = 6'h25;
  localparam logic [5:0] c_OPCODE_LWU = 6'h27;
  localparam logic [5:0] c_OPCODE_SB  = 6'h28;
  localparam logic [5:0] c_OPCODE_SH  = 6'h29;
  localparam logic [5:0] c_OPCODE_SW  = 6'h2B;

  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_LOAD  = 2'b01;
  localparam logic [1:0] c_CAUSE_STORE = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t            r_state;

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_write_data;
  logic [REG_W-1:0]  r_write_register;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic [5:0]        r_opcode;
  logic              r_trap;
  logic [DATA_W-1:0] r_badvaddr;
  logic [1:0]        r_trap_cause;

  logic              w_is_half;
  logic              w_is_word;
  logic              w_mem_access;
  logic              w_misaligned;
  logic [1:0]        w_cause;
  logic              w_run_advance;
  logic              w_pipe_en;
  logic              w_capture;

  // Classify the incoming opcode by access size; byte ops (LB, LBU, SB) and
  // non-memory opcodes fall through as never misaligned.
  always_comb begin
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    case (opcode_in)
      c_OPCODE_LH, c_OPCODE_LHU, c_OPCODE_SH: w_is_half = 1'b1;
      c_OPCODE_LW, c_OPCODE_LWU, c_OPCODE_SW: w_is_word = 1'b1;
      c_OPCODE_LB, c_OPCODE_LBU, c_OPCODE_SB: ;
      default: ;
    endcase
  end

  assign w_mem_access = valid_in & (mem_read_in | mem_write_in);
  assign w_misaligned = w_mem_access &
                        ((w_is_half & alu_result_in[0]) |
                         (w_is_word & (alu_result_in[1:0] != 2'b00)));
  // A store flag wins the cause, so an access that somehow reads and writes
  // is reported as a store.
  assign w_cause      = mem_write_in ? c_CAUSE_STORE : c_CAUSE_LOAD;

  // In RUN the register advances unless stalled; flush overrides stall.
  assign w_run_advance = (r_state == ST_RUN) & (flush_in | ~stall_in);
  // In TRAP the register loads a bubble every cycle, stall or not.
  assign w_pipe_en     = (r_state == ST_TRAP) | w_run_advance;
  // Only a real, aligned instruction in an advancing RUN cycle is captured;
  // every other loading cycle produces a bubble.
  assign w_capture     = w_run_advance & ~flush_in & valid_in & ~w_misaligned;

  // Pipeline payload: either captured from EX or cleared to a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid          <= 1'b0;
      r_alu_result     <= '0;
      r_write_data     <= '0;
      r_write_register <= '0;
      r_reg_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_to_reg     <= 1'b0;
      r_opcode         <= '0;
    end else if (w_pipe_en) begin
      r_valid          <= w_capture;
      r_alu_result     <= w_capture ? alu_result_in     : '0;
      r_write_data     <= w_capture ? write_data_in     : '0;
      r_write_register <= w_capture ? write_register_in : '0;
      // Writes to register 0 are dropped here so later stages never see them.
      r_reg_write      <= w_capture & reg_write_in & (write_register_in != '0);
      r_mem_read       <= w_capture & mem_read_in;
      r_mem_write      <= w_capture & mem_write_in;
      r_mem_to_reg     <= w_capture & mem_to_reg_in;
      r_opcode         <= w_capture ? opcode_in : '0;
    end
  end

  // Trap state machine: records the first misaligned access and parks in
  // TRAP until acknowledged; the fault address and cause persist afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_trap       <= 1'b0;
      r_badvaddr   <= '0;
      r_trap_cause <= c_CAUSE_NONE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_run_advance && !flush_in && w_misaligned) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_badvaddr   <= alu_result_in;
            r_trap_cause <= w_cause;
          end
        end
        ST_TRAP: begin
          if (trap_ack_in) begin
            r_state <= ST_RUN;
            r_trap  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_trap  <= 1'b0;
        end
      endcase
    end
  end

`ifdef EX_MEM_REG_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_traps;
  logic        w_trap_taken;

  assign w_trap_taken = w_run_advance & ~flush_in & w_misaligned;

  // Event counters; clear beats increment and the counts wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_traps  <= '0;
    end else if (perf_clear_in) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_traps  <= '0;
    end else begin
      if (w_capture && mem_read_in)  r_perf_loads  <= r_perf_loads  + 32'd1;
      if (w_capture && mem_write_in) r_perf_stores <= r_perf_stores + 32'd1;
      if (w_trap_taken)              r_perf_traps  <= r_perf_traps  + 32'd1;
    end
  end

  assign perf_loads_out  = r_perf_loads;
  assign perf_stores_out = r_perf_stores;
  assign perf_traps_out  = r_perf_traps;
`endif

  assign valid_out          = r_valid;
  assign alu_result_out     = r_alu_result;
  assign write_data_out     = r_write_data;
  assign write_register_out = r_write_register;
  assign reg_write_out      = r_reg_write;
  assign mem_read_out       = r_mem_read;
  assign mem_write_out      = r_mem_write;
  assign mem_to_reg_out     = r_mem_to_reg;
  assign opcode_out         = r_opcode;
  assign trap_out           = r_trap;
  assign badvaddr_out       = r_badvaddr;
  assign trap_cause_out     = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
//  Module      : tb_ex_mem_reg
//  Description : Directed self-checking bench for ex_mem_reg. Covers reset,
//                stall/flush, the alignment matrix, trap hold/acknowledge,
//                register-0 write suppression and asynchronous reset in
//                TRAP; counters are checked when EX_MEM_REG_PERF_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] c_ADD = 6'h00;
  localparam logic [5:0] c_LB  = 6'h20;
  localparam logic [5:0] c_LH  = 6'h21;
  localparam logic [5:0] c_LW  = 6'h23;
  localparam logic [5:0] c_LHU = 6'h25;
  localparam logic [5:0] c_SB  = 6'h28;
  localparam logic [5:0] c_SH  = 6'h29;
  localparam logic [5:0] c_SW  = 6'h2B;

  logic              clk;
  logic              reset;
  logic              stall_in;
  logic              flush_in;
  logic              valid_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] write_data_in;
  logic [REG_W-1:0]  write_register_in;
  logic              reg_write_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              mem_to_reg_in;
  logic [5:0]        opcode_in;
  logic              trap_ack_in;
  logic              valid_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] write_data_out;
  logic [REG_W-1:0]  write_register_out;
  logic              reg_write_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic              mem_to_reg_out;
  logic [5:0]        opcode_out;
  logic              trap_out;
  logic [DATA_W-1:0] badvaddr_out;
  logic [1:0]        trap_cause_out;
`ifdef EX_MEM_REG_PERF_EN
  logic              perf_clear_in;
  logic [31:0]       perf_loads_out;
  logic [31:0]       perf_stores_out;
  logic [31:0]       perf_traps_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .valid_in          (valid_in),
    .alu_result_in     (alu_result_in),
    .write_data_in     (write_data_in),
    .write_register_in (write_register_in),
    .reg_write_in      (reg_write_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .opcode_in         (opcode_in),
    .trap_ack_in       (trap_ack_in),
`ifdef EX_MEM_REG_PERF_EN
    .perf_clear_in     (perf_clear_in),
    .perf_loads_out    (perf_loads_out),
    .perf_stores_out   (perf_stores_out),
    .perf_traps_out    (perf_traps_out),
`endif
    .valid_out         (valid_out),
    .alu_result_out    (alu_result_out),
    .write_data_out    (write_data_out),
    .write_register_out(write_register_out),
    .reg_write_out     (reg_write_out),
    .mem_read_out      (mem_read_out),
    .mem_write_out     (mem_write_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .opcode_out        (opcode_out),
    .trap_out          (trap_out),
    .badvaddr_out      (badvaddr_out),
    .trap_cause_out    (trap_cause_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction on the EX side.
  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    valid_in          = v;
    opcode_in         = op;
    alu_result_in     = addr;
    write_data_in     = wd;
    write_register_in = rd;
    reg_write_in      = rw;
    mem_read_in       = mr;
    mem_write_in      = mw;
    mem_to_reg_in     = m2r;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, valid_out, 0);
    chk({tag, ".alu"}, alu_result_out, 0);
    chk({tag, ".wdata"}, write_data_out, 0);
    chk({tag, ".rw"}, reg_write_out, 0);
    chk({tag, ".mr"}, mem_read_out, 0);
    chk({tag, ".mw"}, mem_write_out, 0);
    chk({tag, ".op"}, opcode_out, 0);
  endtask

  initial begin
    reset       = 1'b0;
    stall_in    = 1'b0;
    flush_in    = 1'b0;
    trap_ack_in = 1'b0;
`ifdef EX_MEM_REG_PERF_EN
    perf_clear_in = 1'b0;
`endif
    drive(1, c_LW, 32'h10, 32'h0, 5'd2, 1, 1, 0, 1);

    // Reset held across edges with a live instruction: everything stays 0.
    step();
    step();
    chk_bubble("reset");
    chk("reset.trap", trap_out, 0);
    chk("reset.bad", badvaddr_out, 0);
    chk("reset.cause", trap_cause_out, 0);

    // Release reset; the LW 0x10 is captured on the next edge.
    reset = 1'b1;
    step();
    chk("lw10.valid", valid_out, 1);
    chk("lw10.mr", mem_read_out, 1);
    chk("lw10.alu", alu_result_out, 32'h10);
    chk("lw10.trap", trap_out, 0);
    chk("lw10.rw", reg_write_out, 1);

    // Capture SW, then stall three cycles while the inputs change.
    drive(1, c_SW, 32'h20, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0);
    step();
    chk("sw20.mw", mem_write_out, 1);
    chk("sw20.alu", alu_result_out, 32'h20);
    chk("sw20.wdata", write_data_out, 32'hDEADBEEF);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, c_LW, 32'h99 + i, 32'h1111 * i, 5'd4, 1, 1, 0, 1);
      step();
      chk("stall.op", opcode_out, c_SW);
      chk("stall.alu", alu_result_out, 32'h20);
      chk("stall.wdata", write_data_out, 32'hDEADBEEF);
      chk("stall.mw", mem_write_out, 1);
    end
    // Flush beats stall.
    flush_in = 1'b1;
    step();
    chk_bubble("flush");
    flush_in = 1'b0;
    stall_in = 1'b0;

    // Alignment matrix: LH 0x21 traps as a load.
    drive(1, c_LH, 32'h21, 32'h0, 5'd3, 1, 1, 0, 1);
    step();
    chk("lh21.trap", trap_out, 1);
    chk("lh21.cause", trap_cause_out, 2'b01);
    chk("lh21.bad", badvaddr_out, 32'h21);
    chk("lh21.mr", mem_read_out, 0);
    chk("lh21.valid", valid_out, 0);
    drive(0, c_ADD, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    trap_ack_in = 1'b1;
    step();
    trap_ack_in = 1'b0;
    chk("ack1.trap", trap_out, 0);

    // SW 0x22 traps as a store.
    drive(1, c_SW, 32'h22, 32'h55, 5'd0, 0, 0, 1, 0);
    step();
    chk("sw22.trap", trap_out, 1);
    chk("sw22.cause", trap_cause_out, 2'b10);
    chk("sw22.bad", badvaddr_out, 32'h22);
    drive(0, c_ADD, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    trap_ack_in = 1'b1;
    step();
    trap_ack_in = 1'b0;
    chk("ack2.trap", trap_out, 0);
    chk("ack2.cause", trap_cause_out, 2'b10);

    // LB 0x23 and LHU 0x22 are aligned.
    drive(1, c_LB, 32'h23, 32'h0, 5'd3, 1, 1, 0, 1);
    step();
    chk("lb23.trap", trap_out, 0);
    chk("lb23.valid", valid_out, 1);
    chk("lb23.alu", alu_result_out, 32'h23);
    chk("lb23.rd", write_register_out, 5'd3);
    chk("lb23.m2r", mem_to_reg_out, 1);
    drive(1, c_LHU, 32'h22, 32'h0, 5'd6, 1, 1, 0, 1);
    step();
    chk("lhu22.trap", trap_out, 0);
    chk("lhu22.op", opcode_out, c_LHU);
    chk("lhu22.alu", alu_result_out, 32'h22);

    // LW 0x05 traps; TRAP then squashes everything, stall or not.
    drive(1, c_LW, 32'h05, 32'h0, 5'd7, 1, 1, 0, 1);
    step();
    chk("lw05.trap", trap_out, 1);
    chk("lw05.bad", badvaddr_out, 32'h05);
    for (int i = 0; i < 4; i++) begin
      drive(1, c_ADD, 32'h1234, 32'h0, 5'd8, 1, 0, 0, 0);
      stall_in = (i == 1);
      step();
      chk_bubble("trap_hold");
      chk("trap_hold.trap", trap_out, 1);
    end
    stall_in = 1'b0;
    // A misaligned store inside TRAP records nothing new.
    drive(1, c_SH, 32'h33, 32'h0, 5'd0, 0, 0, 1, 0);
    step();
    chk("trap_sh.bad", badvaddr_out, 32'h05);
    chk("trap_sh.cause", trap_cause_out, 2'b01);
    chk("trap_sh.mw", mem_write_out, 0);

    // Acknowledge with SB 0x40 presented: SB is squashed.
    drive(1, c_SB, 32'h40, 32'hAB, 5'd0, 0, 0, 1, 0);
    trap_ack_in = 1'b1;
    step();
    trap_ack_in = 1'b0;
    chk("ack_sb.trap", trap_out, 0);
    chk("ack_sb.valid", valid_out, 0);
    chk("ack_sb.mw", mem_write_out, 0);
    chk("ack_sb.bad", badvaddr_out, 32'h05);
    drive(1, c_LW, 32'h44, 32'h0, 5'd9, 1, 1, 0, 1);
    step();
    chk("lw44.valid", valid_out, 1);
    chk("lw44.mr", mem_read_out, 1);
    chk("lw44.alu", alu_result_out, 32'h44);
    chk("lw44.trap", trap_out, 0);
    chk("lw44.bad", badvaddr_out, 32'h05);
    chk("lw44.cause", trap_cause_out, 2'b01);

    // trap_ack_in in RUN is ignored.
    drive(1, c_LW, 32'h48, 32'h0, 5'd9, 1, 1, 0, 1);
    trap_ack_in = 1'b1;
    step();
    trap_ack_in = 1'b0;
    chk("ackrun.valid", valid_out, 1);
    chk("ackrun.alu", alu_result_out, 32'h48);
    chk("ackrun.trap", trap_out, 0);

    // Register 0 writes are suppressed; other registers pass through.
    drive(1, c_ADD, 32'h77, 32'h0, 5'd0, 1, 0, 0, 0);
    step();
    chk("r0.rw", reg_write_out, 0);
    chk("r0.valid", valid_out, 1);
    drive(1, c_ADD, 32'h78, 32'h0, 5'd5, 1, 0, 0, 0);
    step();
    chk("r5.rw", reg_write_out, 1);
    chk("r5.rd", write_register_out, 5'd5);

    // Invalid input: captured as a bubble, and a misaligned address is ignored.
    drive(0, c_LW, 32'h03, 32'h9, 5'd4, 1, 1, 0, 1);
    step();
    chk_bubble("inval");
    chk("inval.trap", trap_out, 0);

    // Asynchronous reset while in TRAP.
    drive(1, c_LW, 32'h07, 32'h0, 5'd4, 1, 1, 0, 1);
    step();
    chk("lw07.trap", trap_out, 1);
    drive(0, c_ADD, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.trap", trap_out, 0);
    chk("areset.bad", badvaddr_out, 0);
    chk("areset.cause", trap_cause_out, 0);
    step();
    reset = 1'b1;
    // Back in RUN: an aligned load is captured directly.
    drive(1, c_LW, 32'h0C, 32'h0, 5'd4, 1, 1, 0, 1);
    step();
    chk("postrst.valid", valid_out, 1);
    chk("postrst.trap", trap_out, 0);

`ifdef EX_MEM_REG_PERF_EN
    // Counters start from the reset above; the LW 0x0C counts as one load.
    drive(1, c_LW, 32'h100, 32'h0, 5'd4, 1, 1, 0, 1);
    step();
    drive(1, c_SW, 32'h108, 32'h5, 5'd0, 0, 0, 1, 0);
    step();
    drive(1, c_LW, 32'h10C, 32'h0, 5'd4, 1, 1, 0, 1);
    stall_in = 1'b1;
    step();
    stall_in = 1'b0;
    drive(1, c_LH, 32'h101, 32'h0, 5'd4, 1, 1, 0, 1);
    step();
    drive(1, c_LW, 32'h110, 32'h0, 5'd4, 1, 1, 0, 1);
    trap_ack_in = 1'b1;
    step();
    trap_ack_in = 1'b0;
    drive(0, c_ADD, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    chk("perf.loads", perf_loads_out, 2);
    chk("perf.stores", perf_stores_out, 1);
    chk("perf.traps", perf_traps_out, 1);
    drive(1, c_LW, 32'h120, 32'h0, 5'd4, 1, 1, 0, 1);
    perf_clear_in = 1'b1;
    step();
    perf_clear_in = 1'b0;
    chk("perf.clr_loads", perf_loads_out, 0);
    chk("perf.clr_stores", perf_stores_out, 0);
    chk("perf.clr_traps", perf_traps_out, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
